// File: rtl/adf4158_cfg_sequencer_if.sv
// Host/PLL-side signal bundle for the ADF4158 configuration sequencer.
// Field names follow the sequencer's view: i_* it consumes, o_* it drives.
interface adf4158_cfg_sequencer_if;
    logic        i_cfg_we;
    logic [2:0]  i_cfg_addr;
    logic [31:0] i_cfg_wdata;
    logic        i_start_all;
    logic        i_start_one;
    logic [2:0]  i_reg_sel;
    logic        o_pll_clk;
    logic        o_write_data;
    logic        o_load_enable;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_start_all, i_start_one, i_reg_sel,
        input  o_pll_clk, o_write_data, o_load_enable, o_busy, o_done
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_start_all, i_start_one, i_reg_sel,
        output o_pll_clk, o_write_data, o_load_enable, o_busy, o_done
    );
endinterface

// File: rtl/adf4158_cfg_sequencer.sv
// ADF4158 R0..R7 shadow image and 3-wire serialiser (CLK/DATA/LE), MSB first,
// full image sent R7 down to R0 so the final R0 write commits the PLL update.
module adf4158_cfg_sequencer #(
    parameter int CLK_DIV   = 2,
    parameter bit AUTO_INIT = 1'b0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    adf4158_cfg_sequencer_if.slave         bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLK_LO,
        S_CLK_HI,
        S_LE_SETUP,
        S_LE_HIGH
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    state_t            r_state;
    logic [7:0][28:0]  r_shadow;
    logic [30:0]       r_shift;
    logic [4:0]        r_bit_cnt;
    logic [7:0]        r_half;
    logic [2:0]        r_idx;
    logic              r_all;
    logic              r_pending;
    logic              r_init;
    logic              r_pll_clk;
    logic              r_write_data;
    logic              r_load_enable;
    logic              r_busy;
    logic              r_done;

    // Control bits are always replaced by the register index.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^bus.i_cfg_wdata[2:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow <= '0;
        end else if (bus.i_cfg_we) begin
            r_shadow[bus.i_cfg_addr] <= bus.i_cfg_wdata[31:3];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_half        <= '0;
            r_idx         <= '0;
            r_all         <= 1'b0;
            r_pending     <= 1'b0;
            r_init        <= AUTO_INIT;
            r_pll_clk     <= 1'b0;
            r_write_data  <= 1'b0;
            r_load_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && bus.i_start_all) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_init <= 1'b0;
                    if (bus.i_start_all || r_pending || r_init) begin
                        r_all     <= 1'b1;
                        r_idx     <= 3'd7;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end else if (bus.i_start_one) begin
                        r_all   <= 1'b0;
                        r_idx   <= bus.i_reg_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Bit 31 goes straight to the pin; r_shift holds bits 30..0.
                    r_write_data <= r_shadow[r_idx][28];
                    r_shift      <= {r_shadow[r_idx][27:0], r_idx};
                    r_bit_cnt    <= 5'd31;
                    r_half       <= HALF_LAST;
                    r_state      <= S_CLK_LO;
                end
                S_CLK_LO: begin
                    if (r_half == 8'd0) begin
                        r_half    <= HALF_LAST;
                        r_pll_clk <= 1'b1;
                        r_state   <= S_CLK_HI;
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                S_CLK_HI: begin
                    if (r_half == 8'd0) begin
                        r_half    <= HALF_LAST;
                        r_pll_clk <= 1'b0;
                        if (r_bit_cnt == 5'd0) begin
                            r_write_data <= 1'b0;
                            r_state      <= S_LE_SETUP;
                        end else begin
                            r_write_data <= r_shift[30];
                            r_shift      <= {r_shift[29:0], 1'b0};
                            r_bit_cnt    <= r_bit_cnt - 5'd1;
                            r_state      <= S_CLK_LO;
                        end
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                S_LE_SETUP: begin
                    if (r_half == 8'd0) begin
                        r_half        <= HALF_LAST;
                        r_load_enable <= 1'b1;
                        r_state       <= S_LE_HIGH;
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                S_LE_HIGH: begin
                    if (r_half == 8'd0) begin
                        r_load_enable <= 1'b0;
                        if (r_all && r_idx != 3'd0) begin
                            r_idx   <= r_idx - 3'd1;
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_pll_clk     = r_pll_clk;
    assign bus.o_write_data  = r_write_data;
    assign bus.o_load_enable = r_load_enable;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
endmodule

// File: tb/tb_adf4158_cfg_sequencer.sv
// Bench for adf4158_cfg_sequencer: a pin-level monitor rebuilds words from the
// 3-wire bus and checks them against a shadow-image model and cycle formulas.
module tb_adf4158_cfg_sequencer;
    localparam int CD      = 2;
    localparam int CD2     = 1;
    localparam int WORD_T  = 1 + 66 * CD;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    adf4158_cfg_sequencer_if bus();
    adf4158_cfg_sequencer_if bus2();

    adf4158_cfg_sequencer #(.CLK_DIV(CD), .AUTO_INIT(1'b0)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus));
    adf4158_cfg_sequencer #(.CLK_DIV(CD2), .AUTO_INIT(1'b1)) dut2 (
        .i_clk(clk), .i_reset(rst2), .bus(bus2));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] shadow_m [8];

    // pin monitor
    int cyc = 0, nbits = 0, le_run = 0, last_fall = 0, busy_cycles = 0, stab_err = 0;
    logic p_pclk = 0, p_le = 0, p_busy = 0, p_wd = 0;
    logic [31:0] shreg = 0;
    logic [31:0] words_q[$];
    int bits_q[$], le_len_q[$], le_gap_q[$], done_q[$], rise_q[$], fall_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nbits = 0;
            shreg = 0;
        end else begin
            if (bus.o_pll_clk && !p_pclk) begin
                shreg = {shreg[30:0], bus.o_write_data};
                nbits++;
            end
            if (bus.o_pll_clk && p_pclk && bus.o_write_data != p_wd) stab_err++;
            if (!bus.o_pll_clk && p_pclk) last_fall = cyc;
            if (bus.o_load_enable && !p_le) begin
                words_q.push_back(shreg);
                bits_q.push_back(nbits);
                le_gap_q.push_back(cyc - last_fall);
                nbits = 0;
                le_run = 0;
            end
            if (bus.o_load_enable) le_run++;
            if (!bus.o_load_enable && p_le) le_len_q.push_back(le_run);
            if (bus.o_busy) busy_cycles++;
            if (bus.o_busy && !p_busy) rise_q.push_back(cyc);
            if (!bus.o_busy && p_busy) fall_q.push_back(cyc);
            if (bus.o_done) done_q.push_back(cyc);
        end
        p_pclk = bus.o_pll_clk;
        p_le   = bus.o_load_enable;
        p_busy = bus.o_busy;
        p_wd   = bus.o_write_data;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words_q.delete(); bits_q.delete(); le_len_q.delete(); le_gap_q.delete();
        done_q.delete(); rise_q.delete(); fall_q.delete();
        busy_cycles = 0;
        stab_err = 0;
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        bus.i_cfg_we = 1'b1;
        bus.i_cfg_addr = 3'(a);
        bus.i_cfg_wdata = d;
        step();
        bus.i_cfg_we = 1'b0;
        shadow_m[a] = {d[31:3], 3'(a)};
    endtask

    task automatic pulse(input logic all, input logic one, input int sel);
        bus.i_start_all = all;
        bus.i_start_one = one;
        bus.i_reg_sel = 3'(sel);
        step();
        bus.i_start_all = 1'b0;
        bus.i_start_one = 1'b0;
    endtask

    task automatic wait_done(input int n, input int max, input string nm);
        int k = 0;
        while (done_q.size() < n && k < max) begin
            step();
            k++;
        end
        vectors++;
        if (done_q.size() < n) begin
            miscompares++;
            $display("FAIL %s: done pulses %0d, required %0d within %0d cycles", nm, done_q.size(), n, max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if ({bus.o_pll_clk, bus.o_write_data, bus.o_load_enable, bus.o_busy, bus.o_done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required 00000",
                {bus.o_pll_clk, bus.o_write_data, bus.o_load_enable, bus.o_busy, bus.o_done});
        end
        rst = 1'b0;
        repeat (3) step();
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy %b, required 0", bus.o_busy);
        end
        for (int i = 0; i < 8; i++) shadow_m[i] = 32'(i);
    endtask

    task automatic test_single();
        int c0;
        clear_mon();
        write_reg(3, 32'hDEADBEEF);
        c0 = cyc;
        pulse(1'b0, 1'b1, 3);
        wait_done(1, 400, "single_done");
        repeat (5) step();
        vectors++;
        if (busy_cycles != 133) begin
            miscompares++; $display("FAIL single_busy_len: got %0d, required 133", busy_cycles);
        end
        vectors++;
        if (words_q.size() != 1 || words_q[0] !== 32'hDEADBEEB || bits_q[0] != 32) begin
            miscompares++; $display("FAIL single_word: %0d words, first %h, required 1 word deadbeeb",
                words_q.size(), (words_q.size() > 0) ? words_q[0] : 32'hx);
        end
        vectors++;
        if (le_len_q.size() != 1 || le_len_q[0] != CD || le_gap_q[0] != CD) begin
            miscompares++; $display("FAIL single_le: pulses %0d len %0d gap %0d, required 1 len %0d gap %0d",
                le_len_q.size(), (le_len_q.size() > 0) ? le_len_q[0] : -1,
                (le_gap_q.size() > 0) ? le_gap_q[0] : -1, CD, CD);
        end
        vectors++;
        if (done_q.size() != 1 || rise_q.size() != 1 || rise_q[0] != c0 + 1 || fall_q[0] != done_q[0]) begin
            miscompares++; $display("FAIL single_busy_edges: rise %0d fall %0d done %0d, required rise %0d, fall==done, 1 done",
                (rise_q.size() > 0) ? rise_q[0] : -1, (fall_q.size() > 0) ? fall_q[0] : -1,
                (done_q.size() > 0) ? done_q[0] : -1, c0 + 1);
        end
        vectors++;
        if (stab_err != 0) begin
            miscompares++; $display("FAIL single_data_stable: %0d changes while CLK high, required 0", stab_err);
        end
    endtask

    task automatic test_full(input bit rnd, input string nm);
        clear_mon();
        for (int n = 0; n < 8; n++) write_reg(n, rnd ? 32'($urandom) : 32'h11111110 * n);
        pulse(1'b1, 1'b0, 0);
        wait_done(1, 8 * WORD_T + 50, nm);
        repeat (5) step();
        vectors++;
        if (words_q.size() != 8 || le_len_q.size() != 8) begin
            miscompares++; $display("FAIL %s_count: words %0d le %0d, required 8", nm, words_q.size(), le_len_q.size());
        end
        for (int k = 0; k < 8 && k < words_q.size(); k++) begin
            vectors++;
            if (words_q[k] !== shadow_m[7 - k]) begin
                miscompares++; $display("FAIL %s_word%0d: got %h, required %h", nm, k, words_q[k], shadow_m[7 - k]);
            end
        end
        vectors++;
        if (busy_cycles != 8 * WORD_T || stab_err != 0) begin
            miscompares++; $display("FAIL %s_busy: busy %0d stab %0d, required %0d and 0", nm, busy_cycles, stab_err, 8 * WORD_T);
        end
    endtask

    task automatic test_random_single();
        for (int it = 0; it < 4; it++) begin
            int sel;
            clear_mon();
            for (int n = 0; n < 8; n++) write_reg(n, 32'($urandom));
            sel = int'($urandom_range(0, 7));
            pulse(1'b0, 1'b1, sel);
            wait_done(1, 400, "rnd_single_done");
            repeat (3) step();
            vectors++;
            if (words_q.size() != 1 || words_q[0] !== shadow_m[sel] || busy_cycles != WORD_T) begin
                miscompares++; $display("FAIL rnd_single_r%0d: words %0d first %h busy %0d, required 1 %h %0d", sel,
                    words_q.size(), (words_q.size() > 0) ? words_q[0] : 32'hx, busy_cycles, shadow_m[sel], WORD_T);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        pulse(1'b1, 1'b0, 0);
        repeat (100) step();
        pulse(1'b1, 1'b0, 0);
        wait_done(1, 8 * WORD_T + 50, "pend_done1");
        step();
        vectors++;
        if (rise_q.size() != 2 || rise_q[1] != done_q[0] + 1) begin
            miscompares++; $display("FAIL pend_gap: busy rises %0d, second at %0d, required 2 at %0d",
                rise_q.size(), (rise_q.size() > 1) ? rise_q[1] : -1, done_q[0] + 1);
        end
        repeat (50) step();
        pulse(1'b1, 1'b0, 0);
        repeat (250) step();
        pulse(1'b1, 1'b0, 0);
        wait_done(2, 8 * WORD_T + 50, "pend_done2");
        wait_done(3, 8 * WORD_T + 50, "pend_done3");
        repeat (60) step();
        vectors++;
        if (rise_q.size() != 3 || done_q.size() != 3 || rise_q[2] != done_q[1] + 1) begin
            miscompares++; $display("FAIL pend_merge: rises %0d dones %0d, required 3 and 3 with 1 idle gap",
                rise_q.size(), done_q.size());
        end
        vectors++;
        if (words_q.size() != 24 || busy_cycles != 24 * WORD_T) begin
            miscompares++; $display("FAIL pend_words: words %0d busy %0d, required 24 and %0d",
                words_q.size(), busy_cycles, 24 * WORD_T);
        end
    endtask

    task automatic test_collision_live();
        int k = 0;
        clear_mon();
        for (int n = 0; n < 8; n++) write_reg(n, 32'($urandom));
        pulse(1'b1, 1'b1, 2);
        while (words_q.size() < 2 && k < 3 * WORD_T) begin step(); k++; end
        repeat (10) step();
        write_reg(0, 32'hA5A5A5A0);
        repeat (20) step();
        pulse(1'b0, 1'b1, 1);
        wait_done(1, 8 * WORD_T, "live_done");
        repeat (60) step();
        vectors++;
        if (words_q.size() != 8 || rise_q.size() != 1 || done_q.size() != 1) begin
            miscompares++; $display("FAIL live_count: words %0d rises %0d dones %0d, required 8 1 1",
                words_q.size(), rise_q.size(), done_q.size());
        end
        for (int j = 0; j < 8 && j < words_q.size(); j++) begin
            vectors++;
            if (words_q[j] !== shadow_m[7 - j]) begin
                miscompares++; $display("FAIL live_word%0d: got %h, required %h", j, words_q[j], shadow_m[7 - j]);
            end
        end
        vectors++;
        if (words_q.size() != 8 || words_q[7] !== 32'hA5A5A5A0) begin
            miscompares++; $display("FAIL live_r0: got %h, required a5a5a5a0", (words_q.size() == 8) ? words_q[7] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_mon();
        for (int n = 0; n < 8; n++) write_reg(n, 32'($urandom) | 32'h0100_0000);
        pulse(1'b1, 1'b0, 0);
        while (!(words_q.size() == 3 && nbits == 15) && k < 5 * WORD_T) begin step(); k++; end
        vectors++;
        if (!(words_q.size() == 3 && nbits == 15)) begin
            miscompares++; $display("FAIL rstmid_reach: words %0d bits %0d, required 3 and 15", words_q.size(), nbits);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({bus.o_pll_clk, bus.o_load_enable, bus.o_busy, bus.o_write_data, bus.o_done} !== 5'b0) begin
            miscompares++; $display("FAIL rstmid_outputs: got %b, required 00000",
                {bus.o_pll_clk, bus.o_load_enable, bus.o_busy, bus.o_write_data, bus.o_done});
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) shadow_m[i] = 32'(i);
        repeat (20) step();
        vectors++;
        if (words_q.size() != 3 || bus.o_busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_no_le: words %0d busy %b, required 3 and 0", words_q.size(), bus.o_busy);
        end
        clear_mon();
        pulse(1'b0, 1'b1, 4);
        wait_done(1, 400, "rstmid_done");
        repeat (3) step();
        vectors++;
        if (words_q.size() != 1 || words_q[0] !== shadow_m[4]) begin
            miscompares++; $display("FAIL rstmid_shadow: got %h, required %h",
                (words_q.size() > 0) ? words_q[0] : 32'hx, shadow_m[4]);
        end
    endtask

    task automatic test_auto_init();
        logic [31:0] sr = 0;
        logic pp = 0, pl = 0;
        int pcl[$], le_r[$];
        int bcnt = 0, dn = -1;
        step();
        vectors++;
        if (bus2.o_busy !== 1'b0) begin
            miscompares++; $display("FAIL auto_in_reset: busy %b, required 0", bus2.o_busy);
        end
        rst2 = 1'b0;
        step();
        vectors++;
        if (bus2.o_busy !== 1'b1 || bus2.o_pll_clk !== 1'b0) begin
            miscompares++; $display("FAIL auto_load: busy %b clk %b, required 1 0", bus2.o_busy, bus2.o_pll_clk);
        end
        bcnt = 1;
        for (int t = 1; t < 700 && dn < 0; t++) begin
            step();
            if (t <= 4) pcl.push_back(int'(bus2.o_pll_clk));
            if (bus2.o_pll_clk && !pp && le_r.size() == 0) sr = {sr[30:0], bus2.o_write_data};
            if (bus2.o_load_enable && !pl) le_r.push_back(t);
            if (bus2.o_busy) bcnt++;
            if (bus2.o_done) dn = t;
            pp = bus2.o_pll_clk;
            pl = bus2.o_load_enable;
        end
        vectors++;
        if (pcl.size() != 4 || pcl[0] != 0 || pcl[1] != 1 || pcl[2] != 0 || pcl[3] != 1) begin
            miscompares++; $display("FAIL auto_halfper: clk pattern %p, required 0 1 0 1", pcl);
        end
        vectors++;
        if (le_r.size() != 8 || le_r[1] - le_r[0] != 1 + 66 * CD2) begin
            miscompares++; $display("FAIL auto_word_time: le pulses %0d spacing %0d, required 8 and %0d",
                le_r.size(), (le_r.size() > 1) ? le_r[1] - le_r[0] : -1, 1 + 66 * CD2);
        end
        vectors++;
        if (sr !== 32'h0000_0007 || bcnt != 8 * (1 + 66 * CD2) || dn != 8 * (1 + 66 * CD2)) begin
            miscompares++; $display("FAIL auto_seq: word %h busy %0d done_at %0d, required 00000007 %0d %0d",
                sr, bcnt, dn, 8 * (1 + 66 * CD2), 8 * (1 + 66 * CD2));
        end
    endtask

    initial begin
        bus.i_cfg_we = 0; bus.i_cfg_addr = 0; bus.i_cfg_wdata = 0;
        bus.i_start_all = 0; bus.i_start_one = 0; bus.i_reg_sel = 0;
        bus2.i_cfg_we = 0; bus2.i_cfg_addr = 0; bus2.i_cfg_wdata = 0;
        bus2.i_start_all = 0; bus2.i_start_one = 0; bus2.i_reg_sel = 0;
        test_reset();
        test_single();
        test_full(1'b0, "full_pattern");
        test_full(1'b1, "full_random");
        test_random_single();
        test_back_to_back();
        test_collision_live();
        test_reset_mid();
        test_auto_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
